fft_bitrev_buffer: RTL and testbench

FFT_BITREV_BUFFER -- requirements
Module: fft_bitrev_buffer

---
 rtl/fft_pkg.sv | 24 ++
 rtl/fft_pingpong_ram.sv | 30 +++
 rtl/fft_bitrev_buffer.sv | 115 +++++++++++
 tb/tb_fft_bitrev_buffer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants and the bit-reverse helper for the FFT input reorder buffer.
// Both the buffer and its ping-pong storage pull their defaults from here.
package fft_pkg;

  localparam int N_DEFAULT          = 8;
  localparam int DATA_WIDTH_DEFAULT = 8;
  localparam int LOG2N_DEFAULT      = $clog2(N_DEFAULT);
  localparam int FRAME_CNT_W        = 16;
  localparam int BITREV_MAX_W       = 16;

  // Reverses the low 'bits' bits of v; bits above that come back as zero.
  function automatic logic [BITREV_MAX_W-1:0] bitrev(input logic [BITREV_MAX_W-1:0] v,
                                                     input int bits);
    logic [BITREV_MAX_W-1:0] r;
    r = '0;
    for (int b = 0; b < BITREV_MAX_W; b++) begin
      if (b < bits) begin
        r = {r[BITREV_MAX_W-2:0], v[4'(b)]};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two banks of DEPTH {I,Q} words: one synchronous write port, one asynchronous read port.
// Storage carries no reset; the owning controller's full flags decide what is valid.
module fft_pingpong_ram
  import fft_pkg::*;
#(
  parameter int DEPTH = N_DEFAULT,
  parameter int WIDTH = 2 * DATA_WIDTH_DEFAULT,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic             wbank_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             rbank_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [2*DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[{wbank_i, waddr_i}] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[{rbank_i, raddr_i}];

endmodule

// File: rtl/fft_bitrev_buffer.sv
// Ping-pong reorder buffer: frames arrive in natural order and leave in bit-reversed
// order, one bank filling while the other drains, with ready/valid on both sides.
module fft_bitrev_buffer
  import fft_pkg::*;
#(
  parameter int N          = N_DEFAULT,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [DATA_WIDTH-1:0]  i_in,
  input  logic [DATA_WIDTH-1:0]  q_in,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  i_out,
  output logic [DATA_WIDTH-1:0]  q_out,
  output logic                   out_sof,
  output logic                   out_eof,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int               LOG2N = $clog2(N);
  localparam logic [LOG2N-1:0] LAST  = LOG2N'(N - 1);

  logic                   wr_bank_q, wr_bank_d;
  logic                   rd_bank_q, rd_bank_d;
  logic [LOG2N-1:0]       wr_cnt_q, wr_cnt_d;
  logic [LOG2N-1:0]       rd_cnt_q, rd_cnt_d;
  logic [1:0]             full_q, full_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic                    wr_fire, rd_fire;
  logic                    wr_last, rd_last;
  logic [LOG2N-1:0]        rd_addr;
  logic [2*DATA_WIDTH-1:0] rd_data;

  assign in_ready  = ~full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign wr_fire   = enable & in_ready;
  assign rd_fire   = out_valid & out_ready;
  assign wr_last   = wr_fire && (wr_cnt_q == LAST);
  assign rd_last   = rd_fire && (rd_cnt_q == LAST);

  // Write and read completions touch different banks' flags, so both apply in one cycle.
  always_comb begin
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    full_d      = full_q;
    frame_cnt_d = frame_cnt_q;

    if (wr_fire) begin
      wr_cnt_d = wr_cnt_q + LOG2N'(1);
      if (wr_last) begin
        wr_cnt_d          = '0;
        wr_bank_d         = ~wr_bank_q;
        full_d[wr_bank_q] = 1'b1;
      end
    end

    if (rd_fire) begin
      rd_cnt_d = rd_cnt_q + LOG2N'(1);
      if (rd_last) begin
        rd_cnt_d          = '0;
        rd_bank_d         = ~rd_bank_q;
        full_d[rd_bank_q] = 1'b0;
        frame_cnt_d       = frame_cnt_q + FRAME_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      full_q      <= '0;
      frame_cnt_q <= '0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      full_q      <= full_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign rd_addr = LOG2N'(bitrev(BITREV_MAX_W'(rd_cnt_q), LOG2N));

  fft_pingpong_ram #(
    .DEPTH (N),
    .WIDTH (2 * DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_fire),
    .wbank_i (wr_bank_q),
    .waddr_i (wr_cnt_q),
    .wdata_i ({i_in, q_in}),
    .rbank_i (rd_bank_q),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  assign i_out     = rd_data[2*DATA_WIDTH-1:DATA_WIDTH];
  assign q_out     = rd_data[DATA_WIDTH-1:0];
  assign out_sof   = out_valid && (rd_cnt_q == '0);
  assign out_eof   = out_valid && (rd_cnt_q == LAST);
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fft_bitrev_buffer.sv
// Scoreboard bench for fft_bitrev_buffer: a frame-level model predicts readiness,
// validity and the bit-reversed output stream, and a monitor checks every cycle.
module tb_fft_bitrev_buffer;

  localparam int N     = 8;
  localparam int DW    = 8;
  localparam int LOG2N = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [DW-1:0] i_in, q_in;
  logic          in_ready, out_valid, out_ready;
  logic [DW-1:0] i_out, q_out;
  logic          out_sof, out_eof;
  logic [15:0]   frame_cnt;

  fft_bitrev_buffer #(.N(N), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .i_in      (i_in),
    .q_in      (q_in),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .i_out     (i_out),
    .q_out     (q_out),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int i;
    int q;
    int sof;
    int eof;
  } exp_t;

  exp_t exp_q[$];
  int   part_i[$];
  int   part_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pend = 0;         // complete frames stored and not yet fully read
  int   rpos = 0;         // samples already read from the oldest pending frame
  int   frames_read = 0;
  int   mode = 0;         // 0: ready high, 1: ready low, 2: toggle, 3: random
  bit   stall_prev = 0;
  int   hold_i, hold_q;

  function automatic int rev(input int k);
    int r = 0;
    for (int b = 0; b < LOG2N; b++)
      if (((k >> b) & 1) == 1) r += 1 << (LOG2N - 1 - b);
    return r;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor and reference model, evaluated on the falling edge.
  always @(negedge clk) begin
    bit   exp_rdy;
    bit   exp_vld;
    exp_t e;
    if (!rst_n) begin
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_sof", int'(out_sof), 0);
      check("rst_eof", int'(out_eof), 0);
      check("rst_frame_cnt", int'(frame_cnt), 0);
      exp_q.delete();
      part_i.delete();
      part_q.delete();
      pend = 0;
      rpos = 0;
      frames_read = 0;
      stall_prev = 0;
    end else begin
      exp_rdy = (pend < 2);
      exp_vld = (pend > 0);
      check("in_ready", int'(in_ready), int'(exp_rdy));
      check("out_valid", int'(out_valid), int'(exp_vld));
      check("frame_cnt", int'(frame_cnt), frames_read % 65536);
      if (stall_prev) begin
        check("hold_valid", int'(out_valid), 1);
        check("hold_i", int'(i_out), hold_i);
        check("hold_q", int'(q_out), hold_q);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("i_out", int'(i_out), e.i);
          check("q_out", int'(q_out), e.q);
          check("out_sof", int'(out_sof), e.sof);
          check("out_eof", int'(out_eof), e.eof);
        end
      end
      stall_prev = out_valid && !out_ready;
      hold_i = int'(i_out);
      hold_q = int'(q_out);

      if (exp_vld && out_ready) begin
        rpos++;
        if (rpos == N) begin
          rpos = 0;
          pend--;
          frames_read++;
        end
      end
      if (exp_rdy && enable) begin
        part_i.push_back(int'(i_in));
        part_q.push_back(int'(q_in));
        if (part_i.size() == N) begin
          for (int r = 0; r < N; r++) begin
            e.i   = part_i[rev(r)];
            e.q   = part_q[rev(r)];
            e.sof = (r == 0) ? 1 : 0;
            e.eof = (r == N - 1) ? 1 : 0;
            exp_q.push_back(e);
          end
          part_i.delete();
          part_q.delete();
          pend++;
        end
      end
    end
  end

  task automatic drive(input bit en, input logic [DW-1:0] di, input logic [DW-1:0] dq);
    @(posedge clk);
    #1;
    enable = en;
    i_in   = di;
    q_in   = dq;
    case (mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      2:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic idle(input int cycles);
    for (int c = 0; c < cycles; c++) drive(1'b0, '0, '0);
  endtask

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b0;
    out_ready = 1'b1;
    i_in      = '0;
    q_in      = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Natural-order ramp: expect 0,4,2,6,1,5,3,7.
    mode = 0;
    for (int k = 0; k < N; k++) drive(1'b1, DW'(k), DW'(k));
    idle(12);

    // Three back-to-back frames at full rate.
    for (int k = 0; k < 3 * N; k++) drive(1'b1, DW'($urandom), DW'($urandom));
    idle(12);

    // Output stalled: two frames fill, the seventeenth sample is refused.
    mode = 1;
    for (int k = 0; k < 2 * N + 1; k++) drive(1'b1, DW'($urandom), DW'($urandom));
    mode = 0;
    idle(24);

    // Output ready toggling every cycle.
    mode = 2;
    for (int k = 0; k < 3 * N; k++) drive(1'b1, DW'($urandom), DW'($urandom));
    idle(48);

    // Reset in the middle of a frame, then a clean frame.
    mode = 0;
    for (int k = 0; k < 5; k++) drive(1'b1, DW'($urandom), DW'($urandom));
    @(posedge clk);
    #1;
    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < N; k++) drive(1'b1, DW'(k + 16), DW'(k + 32));
    idle(12);

    // Sparse input: one sample every third cycle.
    for (int k = 0; k < N; k++) begin
      drive(1'b1, DW'($urandom), DW'($urandom));
      idle(2);
    end
    idle(12);

    // Random enable and random back-pressure.
    mode = 3;
    for (int k = 0; k < 200; k++)
      drive(1'($urandom_range(0, 1)), DW'($urandom), DW'($urandom));
    mode = 0;
    idle(40);

    check("leftover_expected", exp_q.size(), 0);
    check("pending_frames", pend, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
